// File: rtl/program_loader_if.sv
// program_loader_if: byte-stream input, program-memory write port and
// status signals of the program loader.
//   master : stream/command source (start, base_addr, byte_in, byte_valid);
//            observes byte_ready, memory write port and status.
//   slave  : the loader itself.
interface program_loader_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int ROM_WIDTH  = 16,
  parameter int BYTE_WIDTH = 8
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [BYTE_WIDTH-1:0] byte_in;
  logic                  byte_valid;
  logic                  byte_ready;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [ROM_WIDTH-1:0]  mem_wdata;
  logic                  cpu_hold;
  logic                  busy;
  logic                  done;
  logic                  error;
  logic [ADDR_WIDTH:0]   words_written;

  modport master (
    output start, base_addr, byte_in, byte_valid,
    input  byte_ready, mem_we, mem_addr, mem_wdata,
           cpu_hold, busy, done, error, words_written
  );

  modport slave (
    input  start, base_addr, byte_in, byte_valid,
    output byte_ready, mem_we, mem_addr, mem_wdata,
           cpu_hold, busy, done, error, words_written
  );
endinterface

// File: rtl/program_loader.sv
// program_loader: fills program memory from a framed byte stream.
// Frame: [count][hi0][lo0]...[hiN-1][loN-1][xor checksum]; count 0 = 2^BYTE_WIDTH.
// Each hi/lo pair becomes one big-endian word written at base_addr+i.
// Ports:
//   clk, rst : clock (rising edge), async active-high reset
//   bus      : program_loader_if.slave (stream in, memory write port, status)
// All outputs are decoded from registers only.
module program_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int ROM_WIDTH  = 16,   // must be 2*BYTE_WIDTH
  parameter int BYTE_WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  program_loader_if.slave bus
);

  typedef enum logic [2:0] {IDLE, HDR, HI, LO, WRITE, CHK, DONE} state_t;

  // Header value 0 means a full 2^BYTE_WIDTH word image.
  localparam logic [BYTE_WIDTH:0] FULL_COUNT = {1'b1, {BYTE_WIDTH{1'b0}}};
  localparam logic [BYTE_WIDTH:0] ONE_LEFT   = {{BYTE_WIDTH{1'b0}}, 1'b1};

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [BYTE_WIDTH-1:0] hi_q, lo_q, chk_q;
  logic [BYTE_WIDTH:0]   remaining_q;
  logic [ADDR_WIDTH:0]   words_q;
  logic                  err_q;
  logic                  rdy, xfer;

  assign rdy  = (state_q == HDR) || (state_q == HI) || (state_q == LO) || (state_q == CHK);
  assign xfer = rdy && bus.byte_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = HDR;
      HDR:     if (xfer) state_d = HI;
      HI:      if (xfer) state_d = LO;
      LO:      if (xfer) state_d = WRITE;
      // remaining is decremented at the end of this cycle, so one left means last word
      WRITE:   state_d = (remaining_q == ONE_LEFT) ? CHK : HI;
      CHK:     if (xfer) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q      <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      chk_q       <= '0;
      remaining_q <= '0;
      words_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (bus.start) begin
          addr_q  <= bus.base_addr;
          err_q   <= 1'b0;
          words_q <= '0;
          chk_q   <= '0;
        end
        HDR: if (xfer) begin
          remaining_q <= (bus.byte_in == '0) ? FULL_COUNT : {1'b0, bus.byte_in};
          chk_q       <= chk_q ^ bus.byte_in;
        end
        HI: if (xfer) begin
          hi_q  <= bus.byte_in;
          chk_q <= chk_q ^ bus.byte_in;
        end
        LO: if (xfer) begin
          lo_q  <= bus.byte_in;
          chk_q <= chk_q ^ bus.byte_in;
        end
        WRITE: begin
          addr_q      <= addr_q + 1'b1;   // wraps modulo 2^ADDR_WIDTH
          words_q     <= words_q + 1'b1;
          remaining_q <= remaining_q - 1'b1;
        end
        CHK: if (xfer) err_q <= (bus.byte_in != chk_q);
        default: ;
      endcase
    end
  end

  assign bus.byte_ready    = rdy;
  assign bus.mem_we        = (state_q == WRITE);
  assign bus.mem_addr      = addr_q;
  assign bus.mem_wdata     = {hi_q, lo_q};
  assign bus.cpu_hold      = (state_q != IDLE);
  assign bus.busy          = (state_q != IDLE);
  assign bus.done          = (state_q == DONE);
  assign bus.error         = err_q;
  assign bus.words_written = words_q;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: directed frames (nominal, bad checksum, stalls,
// start while busy, async reset) plus a table of randomized frames checked
// against a frame-level model of the expected memory writes.
module tb_program_loader;
  localparam int AW = 8, RW = 16, BW = 8;

  typedef logic [7:0] bq_t[$];
  typedef int         iq_t[$];
  typedef struct packed {logic [AW-1:0] a; logic [RW-1:0] d;} wr_t;
  typedef struct {
    logic [7:0] base; logic [7:0] hdr; bit corrupt; int gap_pct;
    int exp_words; bit exp_err;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  program_loader_if #(.ADDR_WIDTH(AW), .ROM_WIDTH(RW), .BYTE_WIDTH(BW)) ifc();
  program_loader #(.ADDR_WIDTH(AW), .ROM_WIDTH(RW), .BYTE_WIDTH(BW)) dut (
    .clk(clk), .rst(rst), .bus(ifc.slave)
  );

  int  n_pass = 0, n_total = 0;
  wr_t got[$];
  int  done_cnt, hold_cyc, we_consec;
  logic we_prev;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic clear_mon();
    got.delete(); done_cnt = 0; hold_cyc = 0; we_consec = 0; we_prev = 1'b0;
  endtask

  // advance to the next falling edge and record what the DUT shows there
  task automatic tick();
    @(negedge clk);
    if (ifc.mem_we) got.push_back({ifc.mem_addr, ifc.mem_wdata});
    if (ifc.mem_we && we_prev) we_consec++;
    we_prev = ifc.mem_we;
    if (ifc.done) done_cnt++;
    if (ifc.cpu_hold) hold_cyc++;
  endtask

  // drive a whole frame; gaps[i] idle cycles precede byte i; spam keeps
  // start high with a different base_addr for the whole load
  task automatic send_frame(input logic [7:0] base, input bq_t b, input iq_t gaps, input bit spam);
    int bound;
    logic rdy;
    clear_mon();
    tick();
    ifc.start = 1'b1; ifc.base_addr = base; ifc.byte_valid = 1'b0;
    tick();
    check("start_clears_error", ifc.error, 0);
    check("start_clears_words", ifc.words_written, 0);
    check("hold_after_start", ifc.cpu_hold, 1);
    ifc.start = spam;
    if (spam) ifc.base_addr = 8'h80;
    for (int i = 0; i < b.size(); i++) begin
      repeat (gaps[i]) begin ifc.byte_valid = 1'b0; tick(); end
      ifc.byte_valid = 1'b1; ifc.byte_in = b[i];
      bound = 0;
      do begin rdy = ifc.byte_ready; tick(); bound++; end while (!rdy && bound < 100);
      if (!rdy) begin
        check("byte_accept_timeout", 0, 1);
        ifc.byte_valid = 1'b0; ifc.start = 1'b0;
        return;
      end
    end
    ifc.byte_valid = 1'b0;
    bound = 0;
    while (done_cnt == 0 && bound < 10) begin tick(); bound++; end
    ifc.start = 1'b0;
    repeat (2) tick();
  endtask

  // compare what the DUT wrote against the frame's meaning
  task automatic verify(input string tag, input logic [7:0] base, input bq_t b, input int exp_hold);
    int n, bad;
    logic [7:0] x, a;
    n = (b[0] == 8'h00) ? 256 : int'(b[0]);
    x = 8'h00;
    for (int i = 0; i <= 2 * n; i++) x ^= b[i];
    bad = 0;
    for (int i = 0; i < n; i++) begin
      a = base + 8'(i);
      if (i >= got.size() || got[i] !== {a, b[1+2*i], b[2+2*i]}) bad++;
    end
    check({tag, "_write_count"}, got.size(), n);
    check({tag, "_write_mismatches"}, bad, 0);
    check({tag, "_error"}, ifc.error, (b[2*n+1] != x));
    check({tag, "_words_written"}, ifc.words_written, n);
    check({tag, "_done_pulses"}, done_cnt, 1);
    check({tag, "_we_single_cycle"}, we_consec, 0);
    check({tag, "_idle_after"}, {ifc.busy, ifc.cpu_hold, ifc.byte_ready}, 3'b000);
    if (exp_hold >= 0) check({tag, "_hold_cycles"}, hold_cyc, exp_hold);
  endtask

  initial begin
    bq_t  nom, b;
    iq_t  g0, g;
    vec_t vecs[7];
    int   n;
    logic [7:0] x;

    rst = 1'b1;
    ifc.start = 1'b0; ifc.base_addr = '0; ifc.byte_in = '0; ifc.byte_valid = 1'b0;
    clear_mon();
    repeat (2) tick();
    check("rst_outputs", {ifc.byte_ready, ifc.mem_we, ifc.cpu_hold, ifc.busy, ifc.done, ifc.error}, 6'b0);
    check("rst_mem_addr", ifc.mem_addr, 0);
    check("rst_mem_wdata", ifc.mem_wdata, 0);
    check("rst_words", ifc.words_written, 0);
    rst = 1'b0;
    tick();
    check("idle_no_ready", ifc.byte_ready, 0);

    // nominal frame
    nom = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
    g0  = '{0, 0, 0, 0, 0, 0};
    send_frame(8'h00, nom, g0, 1'b0);
    verify("nominal", 8'h00, nom, 9);
    check("nominal_w0", got.size() > 0 ? got[0] : '0, {8'h00, 16'h1234});
    check("nominal_w1", got.size() > 1 ? got[1] : '0, {8'h01, 16'hABCD});

    // bad checksum; error must stay set while idle
    b = nom; b[5] = 8'h43;
    send_frame(8'h00, b, g0, 1'b0);
    verify("badchk", 8'h00, b, 9);
    repeat (5) tick();
    check("badchk_error_sticky", ifc.error, 1);

    // backpressure: 5 stalled cycles in HI, stall across WRITE into CHK
    g = '{0, 5, 0, 0, 0, 6};
    send_frame(8'h20, nom, g, 1'b0);
    verify("stall", 8'h20, nom, 19);

    // start held high with a new base_addr throughout the load
    send_frame(8'h30, nom, g0, 1'b1);
    verify("start_busy", 8'h30, nom, 9);

    // randomized frames
    vecs[0] = '{8'h00, 8'h02, 1'b0,  0,   2, 1'b0};
    vecs[1] = '{8'h10, 8'h05, 1'b0, 30,   5, 1'b0};
    vecs[2] = '{8'hFF, 8'h02, 1'b0,  0,   2, 1'b0};
    vecs[3] = '{8'h40, 8'h03, 1'b1, 20,   3, 1'b1};
    vecs[4] = '{8'h00, 8'h00, 1'b0,  0, 256, 1'b0};
    vecs[5] = '{8'hF0, 8'h20, 1'b0, 50,  32, 1'b0};
    vecs[6] = '{8'h07, 8'h01, 1'b1,  0,   1, 1'b1};
    foreach (vecs[v]) begin
      n = (vecs[v].hdr == 8'h00) ? 256 : int'(vecs[v].hdr);
      b.delete(); g.delete();
      b.push_back(vecs[v].hdr);
      x = vecs[v].hdr;
      for (int i = 0; i < 2 * n; i++) begin
        b.push_back(8'($urandom_range(0, 255)));
        x ^= b[b.size()-1];
      end
      if (vecs[v].corrupt) x ^= 8'($urandom_range(1, 255));
      b.push_back(x);
      for (int i = 0; i < b.size(); i++)
        g.push_back(($urandom_range(0, 99) < vecs[v].gap_pct) ? int'($urandom_range(1, 4)) : 0);
      send_frame(vecs[v].base, b, g, 1'b0);
      verify($sformatf("vec%0d", v), vecs[v].base, b, (vecs[v].gap_pct == 0) ? 3 + 3 * n : -1);
      check($sformatf("vec%0d_tbl_words", v), ifc.words_written, vecs[v].exp_words);
      check($sformatf("vec%0d_tbl_error", v), ifc.error, vecs[v].exp_err);
    end

    // async reset in the middle of a WRITE cycle
    clear_mon();
    tick();
    ifc.start = 1'b1; ifc.base_addr = 8'h50;
    tick();
    ifc.start = 1'b0; ifc.byte_valid = 1'b1; ifc.byte_in = 8'h03;
    n = 0;
    while (!ifc.mem_we && n < 20) begin tick(); n++; end
    check("arst_reached_write", ifc.mem_we, 1);
    #1 rst = 1'b1;
    #1;
    check("arst_we_drops", ifc.mem_we, 0);
    check("arst_hold_drops", {ifc.busy, ifc.cpu_hold}, 2'b00);
    check("arst_addr_cleared", ifc.mem_addr, 0);
    tick();
    rst = 1'b0; ifc.byte_valid = 1'b0;
    tick();
    check("arst_idle", {ifc.byte_ready, ifc.busy, ifc.mem_we}, 3'b000);
    check("arst_words", ifc.words_written, 0);

    // a load after the reset still works
    send_frame(8'hFE, nom, g0, 1'b0);
    verify("post_rst", 8'hFE, nom, 9);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
